// File: rtl/rst_seq_ctrl_if.sv
// Control/status bundle between the reset sequencer and its surroundings.
// Latency: n/a (wires only). Backpressure: none; all signals are level or one-cycle strobes.
// master drives lock/mode/config inputs and observes the reset outputs; slave is the sequencer.
interface rst_seq_ctrl_if;
    logic       pll_locked;
    logic       m0;
    logic       start;
    logic       chan_cfg_valid;
    logic       chan_cfg_rst;
    logic       pll_cfg_rst;
    logic       core_rst_n;
    logic       m0_rst_n;
    logic       start_rst_n;
    logic       chan_rst_n;
    logic       ready;
    logic       lock_timeout;
    logic [2:0] state_o;

    modport master (
        output pll_locked, m0, start, chan_cfg_valid, chan_cfg_rst,
        input  pll_cfg_rst, core_rst_n, m0_rst_n, start_rst_n, chan_rst_n,
        input  ready, lock_timeout, state_o
    );

    modport slave (
        input  pll_locked, m0, start, chan_cfg_valid, chan_cfg_rst,
        output pll_cfg_rst, core_rst_n, m0_rst_n, start_rst_n, chan_rst_n,
        output ready, lock_timeout, state_o
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: PLL reset, lock wait, staged core/m0/start release, channel reset pulses.
// Latency: outputs are registered decodes of the next state and move on the same edge as state_o.
// Backpressure: none; channel requests outside RUN/CHAN_RST are dropped, not queued.
module rst_seq_ctrl #(
    parameter int HOLD_CYC     = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int STAGE_GAP    = 4,
    parameter int CHAN_RST_CYC = 8,
    parameter int CNT_W        = 11
) (
    input  logic         clk,
    input  logic         rst,
    rst_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_PLL_RST    = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_CORE       = 3'd2,
        S_M0_WAIT    = 3'd3,
        S_START_WAIT = 3'd4,
        S_RUN        = 3'd5,
        S_CHAN_RST   = 3'd6
    } state_t;

    typedef struct packed {
        logic pll_cfg_rst;
        logic core_rst_n;
        logic m0_rst_n;
        logic start_rst_n;
        logic chan_rst_n;
        logic ready;
    } rst_out_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CHAN_LAST = CNT_W'(CHAN_RST_CYC - 1);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_seen;
    logic             lock_to_q;
    logic             timeout_hit;
    logic             cnt_clr;
    logic             chan_req;
    rst_out_t         out_q;

    function automatic rst_out_t decode(input state_t s);
        rst_out_t o;
        o = '{pll_cfg_rst: 1'b1, default: 1'b0};
        case (s)
            S_PLL_RST:    o = '{pll_cfg_rst: 1'b1, default: 1'b0};
            S_WAIT_LOCK:  o = '{default: 1'b0};
            S_CORE,
            S_M0_WAIT:    o = '{core_rst_n: 1'b1, default: 1'b0};
            S_START_WAIT: o = '{core_rst_n: 1'b1, m0_rst_n: 1'b1, default: 1'b0};
            S_RUN:        o = '{pll_cfg_rst: 1'b0, default: 1'b1};
            S_CHAN_RST:   o = '{core_rst_n: 1'b1, m0_rst_n: 1'b1, start_rst_n: 1'b1,
                                default: 1'b0};
            default:      o = '{pll_cfg_rst: 1'b1, default: 1'b0};
        endcase
        return o;
    endfunction

    assign chan_req = bus.chan_cfg_valid & bus.chan_cfg_rst;

    // Exit priority once the core is out of reset: lock loss, m0 drop, start drop, channel request.
    always_comb begin
        nxt         = state;
        timeout_hit = 1'b0;
        cnt_clr     = 1'b0;
        case (state)
            S_PLL_RST: begin
                if (cnt == HOLD_LAST) nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (bus.pll_locked && lock_seen) begin
                    nxt = S_CORE;
                end else if (cnt == LOCK_LAST) begin
                    nxt         = S_PLL_RST;
                    timeout_hit = 1'b1;
                end
            end
            S_CORE: begin
                if (!bus.pll_locked)    nxt = S_PLL_RST;
                else if (cnt == GAP_LAST) nxt = S_M0_WAIT;
            end
            S_M0_WAIT: begin
                if (!bus.pll_locked) nxt = S_PLL_RST;
                else if (bus.m0)     nxt = S_START_WAIT;
            end
            S_START_WAIT: begin
                if (!bus.pll_locked) nxt = S_PLL_RST;
                else if (!bus.m0)    nxt = S_M0_WAIT;
                else if (bus.start)  nxt = S_RUN;
            end
            S_RUN: begin
                if (!bus.pll_locked) nxt = S_PLL_RST;
                else if (!bus.m0)    nxt = S_M0_WAIT;
                else if (!bus.start) nxt = S_START_WAIT;
                else if (chan_req)   nxt = S_CHAN_RST;
            end
            S_CHAN_RST: begin
                if (!bus.pll_locked)       nxt = S_PLL_RST;
                else if (!bus.m0)          nxt = S_M0_WAIT;
                else if (!bus.start)       nxt = S_START_WAIT;
                else if (chan_req)         cnt_clr = 1'b1;
                else if (cnt == CHAN_LAST) nxt = S_RUN;
            end
            default: nxt = S_PLL_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            lock_seen <= 1'b0;
            lock_to_q <= 1'b0;
            out_q     <= decode(S_PLL_RST);
        end else begin
            state <= nxt;
            if (nxt != state || cnt_clr) cnt <= '0;
            else                         cnt <= cnt + CNT_W'(1);
            // Lock must be seen twice while already in WAIT_LOCK; a level carried in from PLL_RST does not count.
            lock_seen <= (state == S_WAIT_LOCK) && (nxt == S_WAIT_LOCK) && bus.pll_locked;
            lock_to_q <= lock_to_q | timeout_hit;
            out_q     <= decode(nxt);
        end
    end

    assign bus.pll_cfg_rst  = out_q.pll_cfg_rst;
    assign bus.core_rst_n   = out_q.core_rst_n;
    assign bus.m0_rst_n     = out_q.m0_rst_n;
    assign bus.start_rst_n  = out_q.start_rst_n;
    assign bus.chan_rst_n   = out_q.chan_rst_n;
    assign bus.ready        = out_q.ready;
    assign bus.lock_timeout = lock_to_q;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: per-cycle expected outputs queued at drive time, popped after each edge.
module tb_rst_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rst_seq_ctrl_if bus();

    rst_seq_ctrl #(
        .HOLD_CYC(16), .LOCK_TIMEOUT(1024), .STAGE_GAP(4), .CHAN_RST_CYC(8), .CNT_W(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       r;
        logic       pl;
        logic       m0;
        logic       st;
        logic       cv;
        logic       cr;
        logic [2:0] exp_st;
        logic       exp_lto;
    } vec_t;

    logic [9:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int lowcnt = 0;
    vec_t tbl[14];

    // Expected {state, pll_cfg_rst, core, m0, start, chan, ready, lock_timeout} for a state.
    function automatic logic [9:0] model(input logic [2:0] s, input logic lto);
        logic pll, c, m, st, ch, rdy;
        pll = 1'b0; c = 1'b0; m = 1'b0; st = 1'b0; ch = 1'b0; rdy = 1'b0;
        case (s)
            3'd0: pll = 1'b1;
            3'd1: pll = 1'b0;
            3'd2, 3'd3: c = 1'b1;
            3'd4: begin c = 1'b1; m = 1'b1; end
            3'd5: begin c = 1'b1; m = 1'b1; st = 1'b1; ch = 1'b1; rdy = 1'b1; end
            3'd6: begin c = 1'b1; m = 1'b1; st = 1'b1; end
            default: pll = 1'b1;
        endcase
        return {s, pll, c, m, st, ch, rdy, lto};
    endfunction

    task automatic apply(input logic r, input logic pl, input logic m0v, input logic stv,
                         input logic cv, input logic cr, input logic [2:0] es,
                         input logic elto, input string nm);
        logic [9:0] got;
        logic [9:0] e;
        rst                = r;
        bus.pll_locked     = pl;
        bus.m0             = m0v;
        bus.start          = stv;
        bus.chan_cfg_valid = cv;
        bus.chan_cfg_rst   = cr;
        exp_q.push_back(model(es, elto));
        @(posedge clk);
        #1;
        got = {bus.state_o, bus.pll_cfg_rst, bus.core_rst_n, bus.m0_rst_n, bus.start_rst_n,
               bus.chan_rst_n, bus.ready, bus.lock_timeout};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s @%0t: got state=%0d pll/core/m0/start/chan/rdy/lto=%b, expected state=%0d %b",
                     nm, $time, got[9:7], got[6:0], e[9:7], e[6:0]);
        end
        if (bus.chan_rst_n === 1'b0) lowcnt++;
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // From a visible PLL_RST cycle with cnt=0 and lock held high: n further cycles of bring-up.
    task automatic bring_up(input int n, input logic lto);
        for (int i = 1; i <= n; i++) begin
            logic [2:0] es;
            if (i <= 15)      es = 3'd0;
            else if (i <= 17) es = 3'd1;
            else if (i <= 21) es = 3'd2;
            else if (i == 22) es = 3'd3;
            else if (i == 23) es = 3'd4;
            else              es = 3'd5;
            apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, es, lto, "bring_up");
        end
    endtask

    initial begin
        //            r  pl  m0 st cv cr  state lto
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0}; // idle run
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0}; // strobe without rst bit
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0}; // m0 drop
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0}; // start low holds
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0}; // start drop from run
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0}; // chan reset
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0}; // m0 drop beats pulse
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0}; // request dropped
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0}; // request dropped
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0}; // not queued
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0}; // all at once: lock wins

        // Reset for 5 cycles; the last sample is cycle 0 after release.
        for (int i = 0; i < 5; i++)
            apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "reset");

        // Power-up with lock rising at cycle 30; sample k shows cycle k+1.
        for (int k = 0; k <= 40; k++) begin
            int c;
            logic [2:0] es;
            c = k + 1;
            if (c <= 15)      es = 3'd0;
            else if (c < 32)  es = 3'd1;
            else if (c <= 35) es = 3'd2;
            else if (c == 36) es = 3'd3;
            else if (c == 37) es = 3'd4;
            else              es = 3'd5;
            apply(1'b0, (k >= 30), 1'b1, 1'b1, 1'b0, 1'b0, es, 1'b0, "powerup");
        end

        for (int i = 0; i < 14; i++)
            apply(tbl[i].r, tbl[i].pl, tbl[i].m0, tbl[i].st, tbl[i].cv, tbl[i].cr,
                  tbl[i].exp_st, tbl[i].exp_lto, "table");

        bring_up(24, 1'b0);

        // Single channel pulse: 8 cycles low.
        lowcnt = 0;
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, "chan_strobe");
        for (int i = 0; i < 7; i++)
            apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, "chan_pulse");
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, "chan_end");
        check_int("chan_pulse_width", lowcnt, 8);

        // Second strobe on the fifth pulse cycle stretches the pulse to 13.
        lowcnt = 0;
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, "ext_strobe");
        for (int i = 0; i < 4; i++)
            apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, "ext_pulse_a");
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, "ext_restrobe");
        for (int i = 0; i < 7; i++)
            apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, "ext_pulse_b");
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, "ext_end");
        check_int("chan_pulse_extended", lowcnt, 13);

        // Lock loss, then lock never comes: timeout after 1024 WAIT_LOCK cycles.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "lock_loss");
        for (int i = 1; i <= 1040; i++) begin
            logic [2:0] es;
            if (i <= 15)        es = 3'd0;
            else if (i <= 1039) es = 3'd1;
            else                es = 3'd0;
            apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, es, (i >= 1040), "lock_timeout");
        end
        bring_up(24, 1'b1);

        // Reset in CORE with cnt=2 clears everything, including the sticky timeout.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, "lock_loss2");
        bring_up(20, 1'b1);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, "mid_reset");
        bring_up(24, 1'b0);

        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
